// File: rtl/vx_gpr_rd_arbiter.sv
// ---------------------------------------------------------------------------
// vx_gpr_rd_arbiter
//
// Arbitrates tensor-core operand-fetch requesters onto the shared rs3 GPR
// read port. Requesters are served round-robin. A requester that starts a
// multi-beat burst keeps the port until its last beat fires. If the
// scoreboard has an instruction waiting (issue_pending) and the tensor core
// has held the port for MAX_STALL consecutive cycles, one idle cycle is
// inserted at the next burst boundary. That idle cycle lets issue proceed.
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   req_valid       per-requester read request
//   req_addr        per-requester GPR address (packed, ADDRW each)
//   req_last        per-requester final-beat marker
//   req_ready       one-hot grant (beat accepted this cycle)
//   issue_pending   scoreboard-side instruction waiting for the read ports
//   rf_valid        arbiter owns the rs3 port this cycle
//   rf_addr         address driven to the rs3 port (0 when idle)
//   rf_data         rs3 RAM output, one cycle after the address
//   rsp_valid       read data returned this cycle
//   rsp_idx         requester owning rsp_data
//   rsp_data        returned data (combinational pass-through of rf_data)
// ---------------------------------------------------------------------------
module vx_gpr_rd_arbiter #(
    parameter int NUM_REQS    = 2,
    parameter int ADDRW       = 8,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int MAX_STALL   = 4,
    localparam int IDXW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int DATAW      = NUM_THREADS * XLEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*ADDRW-1:0] req_addr,
    input  logic [NUM_REQS-1:0]       req_last,
    output logic [NUM_REQS-1:0]       req_ready,
    input  logic                      issue_pending,
    output logic                      rf_valid,
    output logic [ADDRW-1:0]          rf_addr,
    input  logic [DATAW-1:0]          rf_data,
    output logic                      rsp_valid,
    output logic [IDXW-1:0]           rsp_idx,
    output logic [DATAW-1:0]          rsp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        YIELD = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] rr_ptr;
    logic [3:0]      stall_cnt;

    logic [IDXW-1:0] win;
    logic            grant_any;
    logic            win_last;
    logic            yield_now;
    logic [4:0]      stall_inc;
    logic [IDXW-1:0] next_ptr;

    // Grant selection. Reset gates every grant combinationally, so a beat
    // presented while reset is high never fires and never produces a response.
    always_comb begin
        int              idx;
        logic [IDXW-1:0] cand;
        win       = '0;
        grant_any = 1'b0;
        idx       = 0;
        cand      = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // Cyclic search starting at rr_ptr; the first valid wins.
                    for (int k = 0; k < NUM_REQS; k++) begin
                        idx = int'(rr_ptr) + k;
                        if (idx >= NUM_REQS) begin
                            idx = idx - NUM_REQS;
                        end
                        cand = IDXW'(idx);
                        if (!grant_any && req_valid[cand]) begin
                            grant_any = 1'b1;
                            win       = cand;
                        end
                    end
                end
                BURST: begin
                    // Only the owner is eligible. A gap in its valid line
                    // releases the port to issue for that cycle only.
                    if (req_valid[owner]) begin
                        grant_any = 1'b1;
                        win       = owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Port-side outputs follow the grant combinationally.
    always_comb begin
        req_ready = '0;
        rf_addr   = '0;
        if (grant_any) begin
            req_ready[win] = 1'b1;
            rf_addr        = req_addr[int'(win)*ADDRW +: ADDRW];
        end
    end

    assign rf_valid = grant_any;
    assign rsp_data = rf_data;

    // Yield decision uses the count that includes the current granted cycle.
    always_comb begin
        win_last  = req_last[win];
        stall_inc = {1'b0, stall_cnt} + 5'd1;
        yield_now = issue_pending && (stall_inc >= 5'(MAX_STALL));
        if (int'(win) == NUM_REQS - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = win + IDXW'(1);
        end
    end

    // Ownership FSM, round-robin pointer, stall counter and the one-cycle
    // response pipeline. The RAM is registered, so the response index is
    // delayed one cycle to line up with rf_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
        end else begin
            rsp_valid <= grant_any;
            rsp_idx   <= grant_any ? win : '0;

            if (!grant_any) begin
                stall_cnt <= '0;
            end else if (issue_pending && stall_cnt != 4'd15) begin
                stall_cnt <= stall_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if (win_last) begin
                            rr_ptr <= next_ptr;
                            state  <= yield_now ? YIELD : IDLE;
                        end else begin
                            owner <= win;
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (grant_any && win_last) begin
                        rr_ptr <= next_ptr;
                        state  <= yield_now ? YIELD : IDLE;
                    end
                end
                YIELD: begin
                    stall_cnt <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_gpr_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vx_gpr_rd_arbiter
//
// Scoreboard bench for vx_gpr_rd_arbiter. The driver applies one cycle of
// stimulus at a time. It compares the combinational grant outputs against a
// behavioural arbitration model and queues the expected response for the
// following cycle. An independent monitor pops that queue whenever the DUT
// returns data. A bench-side RAM model supplies rf_data one cycle after each
// address.
// ---------------------------------------------------------------------------
module tb_vx_gpr_rd_arbiter;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int NT = 4;
    localparam int XL = 32;
    localparam int MS = 4;
    localparam int DW = NT * XL;
    localparam int IW = 2;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             issue_pending;
    logic             rf_valid;
    logic [AW-1:0]    rf_addr;
    logic [DW-1:0]    rf_data;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_idx;
    logic [DW-1:0]    rsp_data;

    vx_gpr_rd_arbiter #(
        .NUM_REQS   (NR),
        .ADDRW      (AW),
        .NUM_THREADS(NT),
        .XLEN       (XL),
        .MAX_STALL  (MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .issue_pending(issue_pending),
        .rf_valid     (rf_valid),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .rsp_valid    (rsp_valid),
        .rsp_idx      (rsp_idx),
        .rsp_data     (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            tests    = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [AW-1:0] last_addr;

    // Arbitration model: owner (-1 = nobody), round-robin start, count of
    // consecutive granted cycles seen with issue pending, pending yield.
    int m_owner;
    int m_rr;
    int m_streak;
    bit m_yield;

    // The RAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int t = 0; t < NT; t++) begin
            w[t*XL +: XL] = {a, 8'(t), ~a, 8'hA5};
        end
        return w;
    endfunction

    // The compare helper is shared by the driver and the monitor.
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_owner  = -1;
        m_rr     = 0;
        m_streak = 0;
        m_yield  = 1'b0;
    endfunction

    function automatic int model_grant();
        if (m_yield) return -1;
        if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    // Compare the grant outputs against the model, queue the response the
    // model expects, then advance the model by one cycle.
    task automatic checkOutput();
        int            g;
        logic [NR-1:0] exp_ready;
        logic [AW-1:0] exp_addr;
        exp_t          e;
        g         = model_grant();
        exp_ready = '0;
        exp_addr  = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_addr     = req_addr[g*AW +: AW];
        end
        check("req_ready", DW'(req_ready), DW'(exp_ready));
        check("rf_valid", DW'(rf_valid), DW'(g >= 0));
        check("rf_addr", DW'(rf_addr), DW'(exp_addr));
        last_addr = rf_addr;
        if (g >= 0) begin
            e.cyc  = cyc + 1;
            e.idx  = g;
            e.data = ram_word(exp_addr);
            exp_q.push_back(e);
        end
        if (m_yield) begin
            m_yield  = 1'b0;
            m_streak = 0;
        end else if (g < 0) begin
            m_streak = 0;
        end else begin
            if (issue_pending && m_streak < 15) m_streak++;
            if (req_last[g]) begin
                m_owner = -1;
                m_rr    = (g + 1) % NR;
                if (issue_pending && m_streak >= MS) m_yield = 1'b1;
            end else begin
                m_owner = g;
            end
        end
    endtask

    // One clock cycle of stimulus. rf_data models the registered RAM read of
    // the address the DUT drove in the previous cycle.
    task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] l,
                                 input logic [NR*AW-1:0] a, input logic ip);
        @(posedge clk);
        #1;
        cyc++;
        rf_data       = ram_word(last_addr);
        req_valid     = v;
        req_last      = l;
        req_addr      = a;
        issue_pending = ip;
        #3;
        checkOutput();
    endtask

    // Hold reset for two cycles while every requester asks for the port.
    // Nothing may be granted and nothing may be returned.
    task automatic doReset();
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        req_valid = '1;
        req_last  = '1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("reset_ready", DW'(req_ready), DW'(0));
            check("reset_rf_valid", DW'(rf_valid), DW'(0));
            check("reset_rsp_valid", DW'(rsp_valid), DW'(0));
            check("reset_rsp_idx", DW'(rsp_idx), DW'(0));
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        last_addr = '0;
    endtask

    // Response monitor: every returned beat must match the head of the
    // queue, and an expected beat that does not show up is reported.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", DW'(rsp_valid), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", DW'(cyc), DW'(e.cyc));
                    check("rsp_idx", DW'(rsp_idx), DW'(e.idx));
                    check("rsp_data", rsp_data, e.data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing", DW'(rsp_valid), DW'(1));
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*AW-1:0] a;
        logic             ip;

        reset         = 1'b1;
        req_valid     = '0;
        req_last      = '0;
        req_addr      = '0;
        issue_pending = 1'b0;
        rf_data       = '0;
        last_addr     = '0;
        model_reset();
        #2;
        doReset();

        // A single beat from req0 at address 0x12.
        applyStimulus(3'b001, 3'b001, {8'h33, 8'h22, 8'h12}, 1'b0);
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);

        // Two requesters with single beats alternate starting from req0.
        doReset();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(3'b011, 3'b011, 24'($urandom), 1'b0);
        end

        // A req1 burst with a one-cycle valid gap locks req0 out until the
        // last beat of the burst fires.
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        applyStimulus(3'b010, 3'b000, 24'($urandom), 1'b0);
        applyStimulus(3'b001, 3'b000, 24'($urandom), 1'b0);
        applyStimulus(3'b011, 3'b000, 24'($urandom), 1'b0);
        applyStimulus(3'b011, 3'b010, 24'($urandom), 1'b0);
        applyStimulus(3'b001, 3'b001, 24'($urandom), 1'b0);

        // Four back-to-back single beats with issue pending force a yield.
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(3'b001, 3'b001, 24'($urandom), 1'b1);
        end

        // A six-beat burst is never preempted; the yield follows its end.
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(3'b001, (n == 5) ? 3'b001 : 3'b000, 24'($urandom), 1'b1);
        end
        applyStimulus(3'b011, 3'b011, 24'($urandom), 1'b1);
        applyStimulus(3'b011, 3'b011, 24'($urandom), 1'b1);

        // Asynchronous reset during beat 2 of a req1 burst kills the grant
        // and the response in flight before the next edge.
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        applyStimulus(3'b010, 3'b000, 24'($urandom), 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        req_valid = 3'b010;
        req_last  = 3'b000;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_ready", DW'(req_ready), DW'(0));
        check("async_reset_rf_valid", DW'(rf_valid), DW'(0));
        check("async_reset_rsp_valid", DW'(rsp_valid), DW'(0));
        doReset();
        applyStimulus(3'b011, 3'b011, 24'($urandom), 1'b0);
        applyStimulus(3'b011, 3'b011, 24'($urandom), 1'b0);

        // Randomised traffic with bursts, gaps and issue pressure.
        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom);
            l  = 3'($urandom) & 3'($urandom | $urandom);
            a  = 24'($urandom);
            ip = ($urandom_range(0, 9) < 7);
            applyStimulus(v, l, a, ip);
        end

        // Drain outstanding responses.
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        applyStimulus(3'b000, 3'b000, 24'h0, 1'b0);
        @(posedge clk);
        check("queue_drained", DW'(exp_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/vx_gpr_rd_arbiter.md
VX_GPR_RD_ARBITER -- requirements
Module: VX_gpr_rd_arbiter

Interface
REQ-001 Parameter NUM_REQS, default 2, number of tensor-core operand-fetch requesters (1..8).
REQ-002 Parameter ADDRW, default 8, GPR read address width (= LOG2UP(NUM_REGS*ISSUE_RATIO)).
REQ-003 Parameter NUM_THREADS, default 4; parameter XLEN, default 32; per-thread read data width.
REQ-004 Parameter MAX_STALL, default 4, maximum consecutive tensor-core-granted cycles while issue is pending before a forced yield (1..15).
REQ-005 clk  input  1  clock; one clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQS  per-requester read request.
REQ-008 req_addr  input  NUM_REQS*ADDRW  per-requester GPR address.
REQ-009 req_last  input  NUM_REQS  final beat of requester's burst.
REQ-010 req_ready  output  NUM_REQS  beat accepted (grant) this cycle.
REQ-011 issue_pending  input  1  scoreboard-side instruction waiting for the operand read ports.
REQ-012 rf_valid  output  1  arbiter owns shared rs3 read port this cycle (drives tc_rf_valid; stalls issue).
REQ-013 rf_addr  output  ADDRW  address driven to rs3 port (tc_rf_addr).
REQ-014 rf_data  input  NUM_THREADS*XLEN  rs3 RAM output, valid one cycle after address (registered-output RAM).
REQ-015 rsp_valid  output  1  read data returned this cycle.
REQ-016 rsp_idx  output  LOG2UP(NUM_REQS)  requester owning rsp_data.
REQ-017 rsp_data  output  NUM_THREADS*XLEN  returned data; no backpressure, requester must sink it.

Function
REQ-018 Beat fire: req_valid[i] && req_ready[i]; at most one req_ready bit high per cycle; req_ready[i] never high when req_valid[i] low.
REQ-019 rf_valid = OR(req_ready); rf_addr = req_addr of granted requester, 0 when rf_valid low; both combinational.
REQ-020 Response latency exactly 1 cycle: rsp_valid(t+1)=rf_valid(t), rsp_idx(t+1)=granted index(t) (registered); rsp_data=rf_data combinational pass-through.
REQ-021 States: IDLE (no owner), BURST (locked to owner), YIELD (forced issue window).
REQ-022 IDLE: grant round-robin winner among req_valid, search starting at rr_ptr; fire without req_last -> BURST with owner=winner; fire with req_last -> stays IDLE (or YIELD per REQ-026).
REQ-023 BURST: only owner eligible; owner req_valid low -> no grant that cycle, remain BURST (port released to issue for that cycle); other requesters blocked.
REQ-024 BURST: owner fire with req_last -> leave BURST to IDLE (or YIELD per REQ-026).
REQ-025 rr_ptr updates only on fire with req_last: rr_ptr <= winner+1, wrapping NUM_REQS-1 -> 0.
REQ-026 stall_cnt (4 bits): increments (saturating at 15) on each cycle rf_valid && issue_pending; clears on any cycle with rf_valid low; on ownership-ending fire, if issue_pending && stall_cnt+1 >= MAX_STALL -> YIELD.
REQ-027 YIELD: one cycle, no grants, stall_cnt <= 0, next state IDLE unconditionally.
REQ-028 Yield is taken only at burst boundaries; mid-burst never preempted.
REQ-029 issue_pending low: no yield ever taken; stall_cnt still clears on idle cycles.
REQ-030 Simultaneous requests in IDLE: lowest index at or above rr_ptr (cyclic) wins.

Reset
REQ-031 On reset assertion, immediately: state IDLE, rr_ptr 0, stall_cnt 0, rsp_valid 0, rsp_idx 0; req_ready all 0 and rf_valid 0 while reset high.
REQ-032 Reset mid-burst discards ownership; no response issued for a beat granted in the cycle reset asserts.

Verification
REQ-033 NUM_REQS=2, req0 single beat addr 0x12 (last=1) -> cycle t rf_valid=1, rf_addr=0x12, req_ready=01; t+1 rsp_valid=1, rsp_idx=0, rsp_data=rf_data.
REQ-034 Both requesters valid, single beats, rr_ptr=0 -> grants req0, req1, req0 on consecutive cycles.
REQ-035 req1 3-beat burst, req0 valid throughout, req1 drops valid on beat 2 for one cycle -> no grant, rf_valid=0 that cycle, req0 not granted until req1 last beat fires.
REQ-036 MAX_STALL=4, issue_pending=1, req0 4 single beats back-to-back -> 4 grants, then one cycle rf_valid=0 (YIELD), then grants resume.
REQ-037 issue_pending=1, 6-beat burst with MAX_STALL=4 -> all 6 beats granted consecutively, YIELD cycle follows last beat.
REQ-038 reset asserted asynchronously during burst beat 2 -> rf_valid, req_ready, rsp_valid go 0 before next edge; after release, IDLE with rr_ptr=0.
